param_sync_fifo: RTL and testbench
==================================

Name: param_sync_fifo

Overview:
- Parametrised single-clock FIFO built on a register array. Next-generation replacement for the fixed 89-bit x 8 read-result FIFO and the vendor FIFO IPs used in the job/read paths.
- Adds configurable width, depth and programmable thresholds, plus an exact data count.
- Supports standard read mode and first-word-fall-through (FWFT) mode.
- Guarded against overflow and underflow so it can sit directly behind the read-result and job-dispatch logic.

Parameters:
- WIDTH, 89: data width in bits.
- DEPTH, 8: number of entries; power of two, 2 to 1024.
- PROG_FULL_THRESH, 3: prog_full asserts when count >= this value; range 1 to DEPTH.
- PROG_EMPTY_THRESH, 1: prog_empty asserts when count <= this value; range 0 to DEPTH-1.
- FWFT, 0: 0 = standard mode (registered dout after rd_en); 1 = first-word-fall-through.

Ports:
- clk  in  1  clock; all logic on rising edge.
- srst  in  1  reset; synchronous, active-high.
- din  in  WIDTH  write data.
- wr_en  in  1  write request.
- full  out  1  count == DEPTH.
- prog_full  out  1  count >= PROG_FULL_THRESH.
- rd_en  in  1  read request (FWFT: pop/acknowledge of head).
- dout  out  WIDTH  read data.
- valid  out  1  dout holds accepted read data (standard) or a valid head (FWFT).
- empty  out  1  count == 0.
- prog_empty  out  1  count <= PROG_EMPTY_THRESH.
- data_count  out  $clog2(DEPTH+1)  current occupancy, 0 to DEPTH inclusive.

Behaviour:
- Reset (srst high at an edge):
  - rd_ptr, wr_ptr, count and the dout register clear to 0.
  - Outputs after reset: valid=0, empty=1, full=0, prog_empty=1, prog_full=0 (PROG_FULL_THRESH >= 1). data_count=0.
  - Memory array is not reset.
  - srst overrides any same-cycle wr_en/rd_en. A reset mid-stream discards all contents.
- Accept rules:
  - wr_acc = wr_en & ~full.
  - rd_acc = rd_en & ~empty.
  - Rejected requests change no state. Pointers never move on a rejected request.
- Count update: +1 for wr_acc only, -1 for rd_acc only, unchanged for both or neither. All flags derive combinationally from the registered count.
- Simultaneous rd_en and wr_en:
  - When full: read accepted, write rejected. count goes DEPTH to DEPTH-1.
  - When empty: write accepted, read rejected. count goes 0 to 1.
  - Otherwise both accepted; count unchanged.
- Pointers: log2(DEPTH) bits, increment by 1 and wrap naturally from DEPTH-1 to 0.
- Standard mode (FWFT=0):
  - On rd_acc, dout <= mem[rd_ptr] at that edge and valid=1 for the following cycle only.
  - Without rd_acc, dout holds its last value and valid=0.
  - Read latency is 1 cycle from rd_en to dout.
- FWFT mode (FWFT=1):
  - dout = mem[rd_ptr] combinationally; valid = ~empty.
  - rd_en acts as a pop. Data written at edge N is visible on dout and valid after edge N.
  - rd_en with valid=0 is ignored.
- Write-to-empty-deassert latency is 1 cycle in both modes.

Optional Feature:
- Macro PARAM_SYNC_FIFO_ERR_EN.
- When defined, adds two outputs:
  - overflow (1 bit): registered, asserts the cycle after wr_en & full.
  - underflow (1 bit): registered, asserts the cycle after rd_en & empty.
  - Both are single-cycle pulses per offending request, cleared by srst, and never alter FIFO state.
- When undefined, the ports and their logic are absent. Rejected requests are silently dropped.

Test Plan:
- Reset then idle, DEPTH=8 -> empty=1, valid=0, data_count=0, full=0, prog_empty=1, dout=0.
- FWFT=0: write 0x01..0x08 on 8 consecutive cycles -> full=1, data_count=8, prog_full=1 from count 3. A 9th write of 0x09 is rejected. Then 8 reads return 0x01..0x08, each one cycle after rd_en with valid pulses, and empty=1 at the end.
- Wrap-around: push/pop 20 values with sustained rd_en & wr_en at count=4 -> count stays 4, output order is preserved across pointer wrap, no loss.
- Simultaneous rd_en & wr_en when full (count 8) -> count 7, din dropped. When empty -> count 1, valid stays 0.
- FWFT=1: write 0xAA at edge N -> dout=0xAA and valid=1 after edge N. rd_en pops it and empty=1 next cycle. rd_en on empty leaves state unchanged.
- srst asserted with count=5 and wr_en=1 -> count 0, empty=1. With PARAM_SYNC_FIFO_ERR_EN, a read on empty pulses underflow for exactly 1 cycle.

Source files
------------

// File: rtl/param_sync_fifo_if.sv
`default_nettype none
// ============================================================================
// Module   : param_sync_fifo_if
// Purpose  : Bundles the write/read handshake of param_sync_fifo.
//            The master side (the FIFO user) drives din/wr_en/rd_en.
//            The slave side (the FIFO) drives data, flags and the count.
// Ports    : din, wr_en, full, prog_full       - write side
//            rd_en, dout, valid, empty,
//            prog_empty                        - read side
//            data_count                        - occupancy, 0..DEPTH
//            overflow, underflow               - only with PARAM_SYNC_FIFO_ERR_EN
// Revision : 1.0 - initial release
// ============================================================================
interface param_sync_fifo_if #(
  parameter int WIDTH = 89,
  parameter int DEPTH = 8
);
  localparam int c_cnt_w = $clog2(DEPTH + 1);

  logic [WIDTH-1:0]   din;
  logic               wr_en;
  logic               full;
  logic               prog_full;
  logic               rd_en;
  logic [WIDTH-1:0]   dout;
  logic               valid;
  logic               empty;
  logic               prog_empty;
  logic [c_cnt_w-1:0] data_count;
`ifdef PARAM_SYNC_FIFO_ERR_EN
  logic               overflow;
  logic               underflow;

  modport master (
    output din, wr_en, rd_en,
    input  full, prog_full, dout, valid, empty, prog_empty, data_count,
           overflow, underflow
  );

  modport slave (
    input  din, wr_en, rd_en,
    output full, prog_full, dout, valid, empty, prog_empty, data_count,
           overflow, underflow
  );
`else
  modport master (
    output din, wr_en, rd_en,
    input  full, prog_full, dout, valid, empty, prog_empty, data_count
  );

  modport slave (
    input  din, wr_en, rd_en,
    output full, prog_full, dout, valid, empty, prog_empty, data_count
  );
`endif
endinterface
`default_nettype wire

// File: rtl/param_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : param_sync_fifo
// Purpose  : Single-clock FIFO on a register array with exact occupancy
//            count, programmable full/empty thresholds and either a
//            registered (standard) or first-word-fall-through read port.
//            Requests that would overflow or underflow are dropped.
// Ports    : clk   - clock, rising edge
//            srst  - synchronous active-high reset (pointers, count, dout)
//            fifo  - param_sync_fifo_if.slave (din/wr_en/full/prog_full,
//                    rd_en/dout/valid/empty/prog_empty, data_count)
// Options  : PARAM_SYNC_FIFO_ERR_EN - when defined, adds registered
//            overflow/underflow pulses on the interface.
// Revision : 1.0 - initial release
// ============================================================================
module param_sync_fifo #(
  parameter int WIDTH             = 89,
  parameter int DEPTH             = 8,   // power of two, 2..1024
  parameter int PROG_FULL_THRESH  = 3,   // 1..DEPTH
  parameter int PROG_EMPTY_THRESH = 1,   // 0..DEPTH-1
  parameter int FWFT              = 0    // 0: registered dout, 1: fall-through
) (
  input  logic             clk,
  input  logic             srst,
  param_sync_fifo_if.slave fifo
);

  localparam int c_addr_w = $clog2(DEPTH);
  localparam int c_cnt_w  = $clog2(DEPTH + 1);

  logic [WIDTH-1:0]    r_mem [DEPTH];
  logic [c_addr_w-1:0] r_wr_ptr;
  logic [c_addr_w-1:0] r_rd_ptr;
  logic [c_cnt_w-1:0]  r_count;

  logic w_full;
  logic w_empty;
  logic w_wr_acc;
  logic w_rd_acc;

  // All flags come from the registered count only.
  assign w_full   = (r_count == c_cnt_w'(DEPTH));
  assign w_empty  = (r_count == '0);
  assign w_wr_acc = fifo.wr_en & ~w_full;
  assign w_rd_acc = fifo.rd_en & ~w_empty;

  assign fifo.full       = w_full;
  assign fifo.empty      = w_empty;
  assign fifo.prog_full  = (r_count >= c_cnt_w'(PROG_FULL_THRESH));
  assign fifo.prog_empty = (r_count <= c_cnt_w'(PROG_EMPTY_THRESH));
  assign fifo.data_count = r_count;

  // Storage is deliberately not reset; writes are suppressed during srst so
  // a reset edge never disturbs the array.
  always_ff @(posedge clk) begin
    if (w_wr_acc && !srst) begin
      r_mem[r_wr_ptr] <= fifo.din;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (srst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr_acc) begin
        r_wr_ptr <= r_wr_ptr + c_addr_w'(1);
      end
      if (w_rd_acc) begin
        r_rd_ptr <= r_rd_ptr + c_addr_w'(1);
      end
      if (w_wr_acc && !w_rd_acc) begin
        r_count <= r_count + c_cnt_w'(1);
      end else if (!w_wr_acc && w_rd_acc) begin
        r_count <= r_count - c_cnt_w'(1);
      end
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // Head of the queue is presented combinationally; rd_en pops it.
      assign fifo.dout  = r_mem[r_rd_ptr];
      assign fifo.valid = ~w_empty;
    end else begin : g_std
      logic [WIDTH-1:0] r_dout;
      logic             r_valid;

      // dout holds the last popped word; valid marks the cycle after a pop.
      always_ff @(posedge clk) begin
        if (srst) begin
          r_dout  <= '0;
          r_valid <= 1'b0;
        end else begin
          r_valid <= w_rd_acc;
          if (w_rd_acc) begin
            r_dout <= r_mem[r_rd_ptr];
          end
        end
      end

      assign fifo.dout  = r_dout;
      assign fifo.valid = r_valid;
    end
  endgenerate

`ifdef PARAM_SYNC_FIFO_ERR_EN
  logic r_overflow;
  logic r_underflow;

  // Pure observation of rejected requests; FIFO state is untouched.
  always_ff @(posedge clk) begin
    if (srst) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_overflow  <= fifo.wr_en & w_full;
      r_underflow <= fifo.rd_en & w_empty;
    end
  end

  assign fifo.overflow  = r_overflow;
  assign fifo.underflow = r_underflow;
`endif

endmodule
`default_nettype wire

// File: tb/tb_param_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_param_sync_fifo
// Purpose  : Self-checking bench. Drives a standard-mode and an FWFT-mode
//            FIFO with identical stimulus and compares both against a
//            queue-based reference model, plus a directed vector table and
//            hand-written corner-case sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_param_sync_fifo;

  localparam int W  = 89;
  localparam int D  = 8;
  localparam int PF = 3;
  localparam int PE = 1;

  logic clk;
  logic srst;

  param_sync_fifo_if #(.WIDTH(W), .DEPTH(D)) if_std ();
  param_sync_fifo_if #(.WIDTH(W), .DEPTH(D)) if_fw ();

  param_sync_fifo #(
    .WIDTH(W), .DEPTH(D), .PROG_FULL_THRESH(PF), .PROG_EMPTY_THRESH(PE), .FWFT(0)
  ) u_std (
    .clk  (clk),
    .srst (srst),
    .fifo (if_std)
  );

  param_sync_fifo #(
    .WIDTH(W), .DEPTH(D), .PROG_FULL_THRESH(PF), .PROG_EMPTY_THRESH(PE), .FWFT(1)
  ) u_fw (
    .clk  (clk),
    .srst (srst),
    .fifo (if_fw)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: contents as a plain queue, plus the standard-mode
  // output register and the error pulses.
  logic [W-1:0] q [$];
  logic [W-1:0] m_dout;
  logic         m_valid;
  logic         m_ovf;
  logic         m_udf;

  typedef struct {
    logic         wr;
    logic         rd;
    logic [W-1:0] din;
    int           exp_cnt;
    logic         exp_full;
    logic         exp_pfull;
    logic         exp_pempty;
    logic         exp_valid;
    logic [W-1:0] exp_dout;
  } vec_t;

  vec_t vecs [17];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] rnd_data();
    logic [95:0] t;
    t = {$urandom(), $urandom(), $urandom()};
    return t[W-1:0];
  endfunction

  task automatic compare_all();
    int n;
    n = q.size();
    check("std.count",      W'(if_std.data_count), W'(n));
    check("std.empty",      W'(if_std.empty),      W'(n == 0));
    check("std.full",       W'(if_std.full),       W'(n == D));
    check("std.prog_full",  W'(if_std.prog_full),  W'(n >= PF));
    check("std.prog_empty", W'(if_std.prog_empty), W'(n <= PE));
    check("std.valid",      W'(if_std.valid),      W'(m_valid));
    check("std.dout",       if_std.dout,           m_dout);
    check("fw.count",       W'(if_fw.data_count),  W'(n));
    check("fw.valid",       W'(if_fw.valid),       W'(n != 0));
    check("fw.full",        W'(if_fw.full),        W'(n == D));
    if (n > 0) check("fw.dout", if_fw.dout, q[0]);
`ifdef PARAM_SYNC_FIFO_ERR_EN
    check("std.overflow",  W'(if_std.overflow),  W'(m_ovf));
    check("std.underflow", W'(if_std.underflow), W'(m_udf));
    check("fw.overflow",   W'(if_fw.overflow),   W'(m_ovf));
    check("fw.underflow",  W'(if_fw.underflow),  W'(m_udf));
`endif
  endtask

  // One clock: drive both FIFOs, advance the model, compare #1 after the edge.
  task automatic step(input logic wr, input logic rd, input logic [W-1:0] d, input logic rst);
    bit full_pre, empty_pre, wacc, racc;
    srst         = rst;
    if_std.wr_en = wr;  if_fw.wr_en = wr;
    if_std.rd_en = rd;  if_fw.rd_en = rd;
    if_std.din   = d;   if_fw.din   = d;
    @(posedge clk);
    if (rst) begin
      q.delete();
      m_dout  = '0;
      m_valid = 1'b0;
      m_ovf   = 1'b0;
      m_udf   = 1'b0;
    end else begin
      full_pre  = (q.size() == D);
      empty_pre = (q.size() == 0);
      wacc      = wr && !full_pre;
      racc      = rd && !empty_pre;
      m_valid   = racc;
      if (racc) m_dout = q.pop_front();
      if (wacc) q.push_back(d);
      m_ovf = wr && full_pre;
      m_udf = rd && empty_pre;
    end
    #1;
    compare_all();
  endtask

  initial begin
    int pw, pr;
    logic [W-1:0] first;

    // Directed table: fill 1..8, rejected 9th write, then 8 reads.
    for (int i = 0; i < 17; i++) begin
      vecs[i].wr = 1'b0;  vecs[i].rd = 1'b0;  vecs[i].din = '0;
      vecs[i].exp_valid = 1'b0;  vecs[i].exp_dout = '0;
    end
    for (int i = 0; i < 8; i++) begin
      vecs[i].wr         = 1'b1;
      vecs[i].din        = W'(i + 1);
      vecs[i].exp_cnt    = i + 1;
      vecs[i].exp_full   = (i == 7);
      vecs[i].exp_pfull  = (i + 1 >= 3);
      vecs[i].exp_pempty = (i + 1 <= 1);
    end
    vecs[8].wr = 1'b1;  vecs[8].din = W'(9);  vecs[8].exp_cnt = 8;
    vecs[8].exp_full = 1'b1;  vecs[8].exp_pfull = 1'b1;  vecs[8].exp_pempty = 1'b0;
    for (int k = 0; k < 8; k++) begin
      vecs[9+k].rd         = 1'b1;
      vecs[9+k].exp_cnt    = 7 - k;
      vecs[9+k].exp_full   = 1'b0;
      vecs[9+k].exp_pfull  = (7 - k >= 3);
      vecs[9+k].exp_pempty = (7 - k <= 1);
      vecs[9+k].exp_valid  = 1'b1;
      vecs[9+k].exp_dout   = W'(k + 1);
    end

    // Reset, then one idle cycle.
    step(1'b0, 1'b0, '0, 1'b1);
    step(1'b0, 1'b0, '0, 1'b1);
    step(1'b0, 1'b0, '0, 1'b0);
    check("rst.empty",      W'(if_std.empty),      W'(1));
    check("rst.valid",      W'(if_std.valid),      W'(0));
    check("rst.count",      W'(if_std.data_count), W'(0));
    check("rst.full",       W'(if_std.full),       W'(0));
    check("rst.prog_empty", W'(if_std.prog_empty), W'(1));
    check("rst.dout",       if_std.dout,           W'(0));
    check("rst.fw_valid",   W'(if_fw.valid),       W'(0));

    for (int i = 0; i < 17; i++) begin
      step(vecs[i].wr, vecs[i].rd, vecs[i].din, 1'b0);
      check("vec.count",      W'(if_std.data_count), W'(vecs[i].exp_cnt));
      check("vec.full",       W'(if_std.full),       W'(vecs[i].exp_full));
      check("vec.prog_full",  W'(if_std.prog_full),  W'(vecs[i].exp_pfull));
      check("vec.prog_empty", W'(if_std.prog_empty), W'(vecs[i].exp_pempty));
      check("vec.valid",      W'(if_std.valid),      W'(vecs[i].exp_valid));
      if (vecs[i].exp_valid) check("vec.dout", if_std.dout, vecs[i].exp_dout);
    end
    step(1'b0, 1'b0, '0, 1'b0);
    check("drain.empty", W'(if_std.empty), W'(1));
    check("drain.valid", W'(if_std.valid), W'(0));

    // Sustained push/pop at count 4 across pointer wrap.
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, rnd_data(), 1'b0);
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 1'b1, rnd_data(), 1'b0);
      check("wrap.count", W'(if_std.data_count), W'(4));
    end
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, '0, 1'b0);

    // Simultaneous read/write when full: write dropped.
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, W'(16'h100 + i), 1'b0);
    step(1'b1, 1'b1, W'(16'hDEAD), 1'b0);
    check("full_rw.count", W'(if_std.data_count), W'(7));
    check("full_rw.dout",  if_std.dout,           W'(16'h100));
    for (int i = 0; i < 7; i++) begin
      step(1'b0, 1'b1, '0, 1'b0);
      check("full_rw.order", if_std.dout, W'(16'h101 + i));
    end

    // Simultaneous read/write when empty: read rejected.
    step(1'b1, 1'b1, W'(8'h55), 1'b0);
    check("empty_rw.count", W'(if_std.data_count), W'(1));
    check("empty_rw.valid", W'(if_std.valid),      W'(0));
    check("empty_rw.fw",    if_fw.dout,            W'(8'h55));
    step(1'b0, 1'b1, '0, 1'b0);

    // FWFT fall-through, pop, and read on empty.
    step(1'b1, 1'b0, W'(8'hAA), 1'b0);
    check("fwft.dout",  if_fw.dout,        W'(8'hAA));
    check("fwft.valid", W'(if_fw.valid),   W'(1));
    step(1'b0, 1'b1, '0, 1'b0);
    check("fwft.empty", W'(if_fw.empty),   W'(1));
    step(1'b0, 1'b1, '0, 1'b0);
    check("fwft.rd_empty_cnt", W'(if_fw.data_count), W'(0));
`ifdef PARAM_SYNC_FIFO_ERR_EN
    check("udf.pulse", W'(if_fw.underflow), W'(1));
`endif
    step(1'b0, 1'b0, '0, 1'b0);
`ifdef PARAM_SYNC_FIFO_ERR_EN
    check("udf.clear", W'(if_fw.underflow), W'(0));
`endif

    // Reset mid-stream with count 5 and wr_en high.
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, rnd_data(), 1'b0);
    step(1'b1, 1'b0, rnd_data(), 1'b1);
    check("srst.count", W'(if_std.data_count), W'(0));
    check("srst.empty", W'(if_std.empty),      W'(1));
    step(1'b0, 1'b0, '0, 1'b0);

    // Overflow on a write into a full FIFO.
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, rnd_data(), 1'b0);
    first = q[0];
    step(1'b1, 1'b0, rnd_data(), 1'b0);
`ifdef PARAM_SYNC_FIFO_ERR_EN
    check("ovf.pulse", W'(if_std.overflow), W'(1));
`endif
    step(1'b0, 1'b1, '0, 1'b0);
    check("ovf.head", if_std.dout, first);
`ifdef PARAM_SYNC_FIFO_ERR_EN
    check("ovf.clear", W'(if_std.overflow), W'(0));
`endif

    // Randomized traffic with shifting write/read pressure.
    pw = 50;  pr = 50;
    for (int i = 0; i < 3000; i++) begin
      if (i % 200 == 0) begin
        pw = $urandom_range(20, 85);
        pr = $urandom_range(20, 85);
      end
      step(($urandom % 100) < pw, ($urandom % 100) < pr, rnd_data(), ($urandom % 500) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
